// File: rtl/RV32I_definitions.sv
// rtl/RV32I_definitions.sv - shared RV32I constants for the fetch slice
package RV32I_definitions;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IFID_HOLD   = 2'b00,
      IFID_LOAD   = 2'b01,
      IFID_BUBBLE = 2'b10
   } ifid_ctrl_e;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with load/hold/bubble control
module if_id_register
   import RV32I_definitions::*;
(
   input  logic        clk,
   input  logic        reset,
   input  ifid_ctrl_e  ctrl,
   input  logic        misaligned_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] pc4_in,
   input  logic [31:0] instr_in,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_instruction,
   output logic        id_valid,
   output logic        id_misaligned
);

   logic [31:0] pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d;
   logic        valid_q, valid_d, mis_q, mis_d;

   always_comb begin
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
      // Only a misaligned redirect raises the flag; any other edge drops it.
      mis_d   = 1'b0;
      case (ctrl)
         IFID_LOAD: begin
            pc_d    = pc_in;
            pc4_d   = pc4_in;
            instr_d = instr_in;
            valid_d = 1'b1;
         end
         IFID_BUBBLE: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            mis_d   = misaligned_in;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0004;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   assign id_pc          = pc_q;
   assign id_pc4         = pc4_q;
   assign id_instruction = instr_q;
   assign id_valid       = valid_q;
   assign id_misaligned  = mis_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32I instruction fetch: PC, next-PC mux, IMEM address, IF/ID
module if_fetch_unit
   import RV32I_definitions::*;
#(
   parameter int          IMEM_ADDR_WIDTH = 32,
   parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       IF_stall,
   input  logic                       EX_redirect,
   input  logic [31:0]                EX_target,
   output logic [IMEM_ADDR_WIDTH-1:0] IMEM_address,
   input  logic [31:0]                Instruction,
   output logic [31:0]                ID_PC,
   output logic [31:0]                ID_PC4,
   output logic [31:0]                ID_Instruction,
   output logic                       ID_valid,
   output logic                       ID_misaligned,
   output logic [31:0]                PC_current
);

   // PC is always word aligned, so only the word index is stored.
   logic [29:0] pc_q, pc_d;
   ifid_ctrl_e  ifid_ctrl;
   logic        redirect_misaligned;

   always_comb begin
      pc_d                = pc_q;
      ifid_ctrl           = IFID_HOLD;
      redirect_misaligned = 1'b0;
      if (EX_redirect) begin
         pc_d                = EX_target[31:2];
         ifid_ctrl           = IFID_BUBBLE;
         redirect_misaligned = |EX_target[1:0];
      end else if (!IF_stall) begin
         pc_d      = pc_q + 30'd1;
         ifid_ctrl = IFID_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC[31:2];
      else       pc_q <= pc_d;
   end

   assign PC_current = {pc_q, 2'b00};

   generate
      if (IMEM_ADDR_WIDTH > 30) begin : g_addr_ext
         assign IMEM_address = {{(IMEM_ADDR_WIDTH-30){1'b0}}, pc_q};
      end else begin : g_addr_trunc
         assign IMEM_address = pc_q[IMEM_ADDR_WIDTH-1:0];
      end
   endgenerate

   if_id_register u_if_id (
      .clk            (clk),
      .reset          (reset),
      .ctrl           (ifid_ctrl),
      .misaligned_in  (redirect_misaligned),
      .pc_in          ({pc_q, 2'b00}),
      .pc4_in         ({pc_q + 30'd1, 2'b00}),
      .instr_in       (Instruction),
      .id_pc          (ID_PC),
      .id_pc4         (ID_PC4),
      .id_instruction (ID_Instruction),
      .id_valid       (ID_valid),
      .id_misaligned  (ID_misaligned)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed-vector bench for if_fetch_unit
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        IF_stall;
   logic        EX_redirect;
   logic [31:0] EX_target;
   logic [31:0] IMEM_address;
   logic [31:0] Instruction;
   logic [31:0] ID_PC, ID_PC4, ID_Instruction, PC_current;
   logic        ID_valid, ID_misaligned;

   int n_vec = 0;
   int n_bad = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   if_fetch_unit #(.IMEM_ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .IF_stall       (IF_stall),
      .EX_redirect    (EX_redirect),
      .EX_target      (EX_target),
      .IMEM_address   (IMEM_address),
      .Instruction    (Instruction),
      .ID_PC          (ID_PC),
      .ID_PC4         (ID_PC4),
      .ID_Instruction (ID_Instruction),
      .ID_valid       (ID_valid),
      .ID_misaligned  (ID_misaligned),
      .PC_current     (PC_current)
   );

   always #5 clk = ~clk;

   // Combinational ROM: word at index i is 0x0A000000 | i[23:0].
   assign Instruction = 32'h0A00_0000 | {8'h00, IMEM_address[23:0]};

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic valid, input logic mis);
      check_vec({tag, ".ID_PC"}, ID_PC, pc);
      check_vec({tag, ".ID_PC4"}, ID_PC4, pc + 32'd4);
      check_vec({tag, ".ID_Instruction"}, ID_Instruction, ins);
      check_vec({tag, ".ID_valid"}, {31'd0, ID_valid}, {31'd0, valid});
      check_vec({tag, ".ID_misaligned"}, {31'd0, ID_misaligned}, {31'd0, mis});
   endtask

   initial begin
      reset = 1'b1; IF_stall = 1'b0; EX_redirect = 1'b0; EX_target = 32'h0;
      step();
      check_vec("rst.PC", PC_current, 32'h0);
      check_vec("rst.addr", IMEM_address, 32'h0);
      check_id("rst", 32'h0, NOP, 1'b0, 1'b0);

      // Free-running fetch of words 0..3
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_id($sformatf("run%0d", i), 32'(4 * i), 32'h0A00_0000 | 32'(i), 1'b1, 1'b0);
         check_vec($sformatf("run%0d.addr", i), IMEM_address, 32'(i + 1));
      end

      // Re-run to PC=8, then stall two cycles
      reset = 1'b1; step(); reset = 1'b0;
      step(); step();
      check_vec("pre_stall.PC", PC_current, 32'h8);
      IF_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check_vec($sformatf("stall%0d.PC", i), PC_current, 32'h8);
         check_vec($sformatf("stall%0d.addr", i), IMEM_address, 32'h2);
         check_id($sformatf("stall%0d", i), 32'h4, 32'h0A00_0001, 1'b1, 1'b0);
      end
      IF_stall = 1'b0;
      step();
      check_id("resume_c", 32'h8, 32'h0A00_0002, 1'b1, 1'b0);
      step();
      check_id("resume_d", 32'hC, 32'h0A00_0003, 1'b1, 1'b0);
      check_vec("resume_d.PC", PC_current, 32'h10);

      // Redirect to 0x40 from PC=0x10
      EX_redirect = 1'b1; EX_target = 32'h40;
      step();
      check_vec("redir.PC", PC_current, 32'h40);
      check_id("redir", 32'hC, NOP, 1'b0, 1'b0);
      EX_redirect = 1'b0;
      step();
      check_id("redir_tgt", 32'h40, 32'h0A00_0010, 1'b1, 1'b0);

      // Redirect wins over simultaneous stall
      EX_redirect = 1'b1; EX_target = 32'h80; IF_stall = 1'b1;
      step();
      check_vec("redir_stall.PC", PC_current, 32'h80);
      check_id("redir_stall", 32'h40, NOP, 1'b0, 1'b0);
      EX_redirect = 1'b0; IF_stall = 1'b0;
      step();
      check_id("redir_stall_tgt", 32'h80, 32'h0A00_0020, 1'b1, 1'b0);

      // Misaligned redirect flags for exactly one cycle
      EX_redirect = 1'b1; EX_target = 32'h42;
      step();
      check_vec("mis.PC", PC_current, 32'h40);
      check_id("mis", 32'h80, NOP, 1'b0, 1'b1);
      EX_redirect = 1'b0;
      step();
      check_id("mis_clear", 32'h40, 32'h0A00_0010, 1'b1, 1'b0);

      // Reset during stall at PC=0x20
      EX_redirect = 1'b1; EX_target = 32'h20;
      step();
      EX_redirect = 1'b0; IF_stall = 1'b1; reset = 1'b1;
      check_vec("pre_rst.PC", PC_current, 32'h20);
      step();
      check_vec("mid_rst.PC", PC_current, 32'h0);
      check_id("mid_rst", 32'h0, NOP, 1'b0, 1'b0);

      // PC wrap from 0xFFFFFFFC
      reset = 1'b0; IF_stall = 1'b0; EX_redirect = 1'b1; EX_target = 32'hFFFF_FFFC;
      step();
      check_vec("wrap_pre.PC", PC_current, 32'hFFFF_FFFC);
      check_vec("wrap_pre.addr", IMEM_address, 32'h3FFF_FFFF);
      EX_redirect = 1'b0;
      step();
      check_vec("wrap.PC", PC_current, 32'h0);
      check_vec("wrap.ID_PC", ID_PC, 32'hFFFF_FFFC);
      check_vec("wrap.ID_PC4", ID_PC4, 32'h0);
      check_vec("wrap.ID_Instruction", ID_Instruction, 32'h0AFF_FFFF);
      check_vec("wrap.ID_valid", {31'd0, ID_valid}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the RV32I pipeline: owns the program counter, drives the word-indexed instruction memory (IMEM) address, and captures the returned instruction into the IF/ID pipeline register. Accepts stall from the hazard unit and redirect (taken branch / jump) from EX, inserting bubbles as required. Sits between the PC-redirect logic in EX and the ID stage decoder.

## Interface
- IMEM_ADDR_WIDTH, 32: width of IMEM word-index address output.
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- IF_stall  in  1  hold PC and IF/ID contents this cycle.
- EX_redirect  in  1  taken branch/jump resolved in EX; load EX_target.
- EX_target  in  32  byte address of redirect target.
- IMEM_address  out  IMEM_ADDR_WIDTH  word index to IMEM = PC[31:2], zero-extended/truncated.
- Instruction  in  32  combinational IMEM read data for IMEM_address.
- ID_PC  out  32  byte PC of instruction held in IF/ID.
- ID_PC4  out  32  ID_PC + 4.
- ID_Instruction  out  32  instruction held in IF/ID.
- ID_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- ID_misaligned  out  1  redirect target had nonzero bits [1:0]; one-cycle flag, qualifies the bubble.
- PC_current  out  32  current fetch PC (debug/trace).

## Operation
- Priority each edge: reset > EX_redirect > IF_stall > normal advance.
- Reset: PC <= RESET_PC; ID_Instruction <= 32'h0000_0013 (NOP); ID_PC <= 0; ID_PC4 <= 4; ID_valid <= 0; ID_misaligned <= 0.
- Normal: IF/ID <= {PC, PC+4, Instruction}, ID_valid <= 1; PC <= PC + 4 (mod 2^32, wraps silently from 32'hFFFF_FFFC to 0).
- Stall (no redirect): PC and all IF/ID outputs hold; IMEM_address unchanged.
- Redirect (overrides stall): PC <= {EX_target[31:2], 2'b00}; IF/ID <= bubble (NOP, ID_valid=0, ID_PC/ID_PC4 hold previous value); ID_misaligned <= |EX_target[1:0], else 0.
- ID_misaligned clears on the next edge that is not a misaligned redirect.
- Bubble always carries Instruction = NOP so downstream decode is harmless regardless of ID_valid.
- No state machine beyond PC and IF/ID register; a cycle-level valid bit represents the bubble state.

## Timing
- IMEM_address is a pure function of registered PC; IMEM data returns same cycle (combinational ROM).
- Fetch-to-ID latency: 1 cycle (instruction at PC appears on ID_* one edge after PC is presented).
- First valid instruction (RESET_PC) on ID_* at the 1st edge after reset deasserts.
- Redirect penalty: redirect edge produces 1 bubble in IF/ID; target instruction appears on ID_* at the following edge (EX flushes its own younger ID instruction; not this block's concern).
- Stall + redirect same cycle: redirect taken, stall ignored.
- Reset asserted mid-stream: next edge restores reset values regardless of stall/redirect.
- No combinational path from any input to any output except Instruction -> none (Instruction is registered before ID_*).

## Structure
- RV32I_definitions package gains: NOP_INSTR = 32'h0000_0013, DEFAULT_RESET_PC constant.
- One sub-module natural: if_id_register (holds ID_PC, ID_PC4, ID_Instruction, ID_valid, ID_misaligned with load/hold/bubble controls); PC register and next-PC mux stay in if_fetch_unit.
- Top-level wiring: if_fetch_unit.IMEM_address -> IMEM address; IMEM Instruction -> if_fetch_unit.Instruction.

## Test plan
- Reset then 4 free-running edges with IMEM words 0..3 = A,B,C,D -> ID_Instruction A,B,C,D, ID_PC 0,4,8,12, ID_valid=1 from first edge; IMEM_address 0,1,2,3,4.
- Stall high 2 cycles at PC=8 -> PC, IMEM_address=2, ID_* frozen both cycles; resumes with C then D.
- EX_redirect with EX_target=0x40 at PC=0x10 -> next edge ID_valid=0, ID_Instruction=0x00000013, PC=0x40; following edge ID_PC=0x40, ID_valid=1.
- Redirect and stall same cycle, target 0x80 -> PC=0x80, bubble inserted, stall ignored.
- Redirect to 0x42 -> PC=0x40, ID_misaligned=1 for exactly one cycle with ID_valid=0.
- Reset asserted during stall with PC=0x20 -> next edge PC=RESET_PC, ID_valid=0, ID_Instruction=NOP; PC wrap from 0xFFFFFFFC -> 0 checked separately.
